// File: rtl/step_clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : step_clock_ctrl_pkg
//  Description : Shared constants for the single-step clock front end:
//                debouncer FSM state encoding and step counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package step_clock_ctrl_pkg;

    // Debouncer FSM state encoding (2-bit)
    typedef logic [1:0] btn_state_t;

    localparam logic [1:0] c_st_idle        = 2'd0;
    localparam logic [1:0] c_st_deb_press   = 2'd1;
    localparam logic [1:0] c_st_pressed     = 2'd2;
    localparam logic [1:0] c_st_deb_release = 2'd3;

    // Width of the issued-step counter
    localparam int c_step_count_w = 16;

endpackage
`default_nettype wire

// File: rtl/step_clock_ctrl_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : step_clock_ctrl_btn_debouncer
//  Description : Polarity-normalises and synchronises the raw push button,
//                debounces it with a four-state FSM and emits a one-cycle
//                press pulse on the accepted press edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_clock_ctrl_btn_debouncer
    import step_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,  // must be >= 2
    parameter bit BTN_ACTIVE_LOW  = 1'b1
)(
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_btn_level,
    output logic o_press
);

    localparam int             c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               w_btn_norm;
    logic               r_sync1;
    logic               r_sync2;
    btn_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               w_cnt_done;

    // Pressed is always 1 from here on, regardless of board key polarity
    assign w_btn_norm = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;
    assign w_cnt_done = (r_cnt == c_cnt_last);

    // Two-flop synchroniser on the normalised button
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_btn_norm;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: a level change is accepted only after it holds stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_sync2) begin
                        r_state <= c_st_deb_press;
                        r_cnt   <= '0;
                    end
                end
                c_st_deb_press: begin
                    if (!r_sync2) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= c_st_pressed;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_pressed: begin
                    if (!r_sync2) begin
                        r_state <= c_st_deb_release;
                        r_cnt   <= '0;
                    end
                end
                c_st_deb_release: begin
                    if (r_sync2) begin
                        r_state <= c_st_pressed;
                    end else if (w_cnt_done) begin
                        r_state <= c_st_idle;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Press pulse coincides with the edge that raises the debounced level,
    // so the top can register step_en on that same edge.
    assign o_press     = (r_state == c_st_deb_press) && r_sync2 && w_cnt_done;
    assign o_btn_level = r_level;

endmodule
`default_nettype wire

// File: rtl/step_clock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : step_clock_ctrl
//  Description : Single-step front end for the processor core. Produces a
//                registered one-cycle step enable from either a debounced
//                push button (manual) or a free-running divider (run mode),
//                gated by HLT, and counts the issued steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_clock_ctrl
    import step_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,   // must be >= 2
    parameter int RUN_DIV         = 5000000,  // must be >= 2
    parameter bit BTN_ACTIVE_LOW  = 1'b1
)(
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      PBUTTON,
    input  logic                      run_mode,
    input  logic                      HLT,
    output logic                      step_en,
    output logic                      btn_level,
    output logic [c_step_count_w-1:0] step_count
);

    localparam int                 c_div_w    = $clog2(RUN_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(RUN_DIV - 1);

    logic                      w_press;
    logic                      w_btn_level;
    logic [c_div_w-1:0]        r_div;
    logic                      r_run_prev;
    logic                      w_div_hold;
    logic                      w_div_evt;
    logic                      w_evt;
    logic                      w_fire;
    logic                      r_step_en;
    logic [c_step_count_w-1:0] r_step_count;

    step_clock_ctrl_btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debouncer (
        .clk         (CLK),
        .rst         (Reset),
        .i_btn_raw   (PBUTTON),
        .o_btn_level (w_btn_level),
        .o_press     (w_press)
    );

    // Divider is parked at 0 when not running, when halted, and on the edge
    // where run_mode toggles, so the first auto step is a full period away.
    assign w_div_hold = (run_mode != r_run_prev) || !run_mode || HLT;
    assign w_div_evt  = !w_div_hold && (r_div == c_div_last);

    // Only one source is live at a time; HLT drops the event outright
    assign w_evt  = run_mode ? w_div_evt : w_press;
    assign w_fire = w_evt && !HLT;

    // Run-mode divider and run_mode history
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_div      <= '0;
            r_run_prev <= 1'b0;
        end else begin
            r_run_prev <= run_mode;
            if (w_div_hold || (r_div == c_div_last)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end
        end
    end

    // Registered step enable and wrapping step counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_step_en    <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_step_en <= w_fire;
            if (w_fire) begin
                r_step_count <= r_step_count + c_step_count_w'(1);
            end
        end
    end

    assign step_en    = r_step_en;
    assign btn_level  = w_btn_level;
    assign step_count = r_step_count;

endmodule
`default_nettype wire
